mms_load8: RTL and testbench

Upstream feeder for the 8-number max/min selector. Accepts a serial stream of 8-bit samples over a valid/ready handshake and packs 8 consecutive samples into a register window. It then presents them as parallel number0..number7 plus a latched select, holding them stable until the consumer acknowledges. The downstream selector is purely combinational, so this block provides all timing and hold behaviour for that path.

---
 rtl/mms_load8_pkg.sv | 18 +
 rtl/mms_load8_if.sv | 33 +++
 rtl/mms_load8.sv | 89 ++++++++
 tb/tb_mms_load8.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mms_load8_pkg.sv
// Shared constants and types for the mms_load8 sample packer.
package mms_load8_pkg;

    localparam int unsigned N_NUM     = 8;
    localparam int unsigned COUNT_W   = 3;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic SEL_MAX = 1'b1;
    localparam logic SEL_MIN = 1'b0;

    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(N_NUM - 1);

endpackage

// File: rtl/mms_load8_if.sv
// Serial sample input, parallel window output and consumer handshake of mms_load8.
interface mms_load8_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] number0;
    logic [WIDTH-1:0] number1;
    logic [WIDTH-1:0] number2;
    logic [WIDTH-1:0] number3;
    logic [WIDTH-1:0] number4;
    logic [WIDTH-1:0] number5;
    logic [WIDTH-1:0] number6;
    logic [WIDTH-1:0] number7;
    logic             select;
    logic             out_valid;
    logic             out_ack;

    modport master (
        output in_valid, in_data, in_sel, flush, out_ack,
        input  in_ready, number0, number1, number2, number3,
               number4, number5, number6, number7, select, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_sel, flush, out_ack,
        output in_ready, number0, number1, number2, number3,
               number4, number5, number6, number7, select, out_valid
    );
endinterface

// File: rtl/mms_load8.sv
// Packs 8 serial samples into a held parallel window for the combinational
// max/min selector; the window stays frozen until the consumer acknowledges.
module mms_load8
    import mms_load8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mms_load8_if.slave  bus
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   num_q [N_NUM];
    logic [WIDTH-1:0]   num_d [N_NUM];
    logic               select_q, select_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Next-state: flush dominates, then per-state handshake handling
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        num_d    = num_q;
        select_d = select_q;

        if (bus.flush) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.in_valid) begin
                        num_d[count_q] = bus.in_data;
                        if (count_q == '0) begin
                            select_d = bus.in_sel;
                        end
                        count_d = count_q + COUNT_W'(1);
                        if (count_q == LAST_IDX) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ack) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            num_q       <= '{default: '0};
            select_q    <= SEL_MIN;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            num_q       <= num_d;
            select_q    <= select_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.select    = select_q;
    assign bus.number0   = num_q[0];
    assign bus.number1   = num_q[1];
    assign bus.number2   = num_q[2];
    assign bus.number3   = num_q[3];
    assign bus.number4   = num_q[4];
    assign bus.number5   = num_q[5];
    assign bus.number6   = num_q[6];
    assign bus.number7   = num_q[7];

endmodule

// File: tb/tb_mms_load8.sv
// Scoreboard bench for mms_load8: directed scenarios plus random traffic
// checked against a queue-based window model.
module tb_mms_load8;
    import mms_load8_pkg::*;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    mms_load8_if #(.WIDTH(W)) bus ();

    mms_load8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    // Reference model: register file image, latched select, samples of the
    // window in progress, and whether a complete window is on display.
    logic [W-1:0]  m_mem [8];
    logic          m_sel;
    logic [W-1:0]  m_win [$];
    logic          m_hold;
    logic [8*W:0]  exp_q [$];

    task automatic check(input string name, input logic [8*W:0] act, input logic [8*W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8*W:0] model_window();
        logic [8*W:0] v;
        for (int i = 0; i < 8; i++) v[i*W +: W] = m_mem[i];
        v[8*W] = m_sel;
        return v;
    endfunction

    function automatic logic [8*W:0] dut_window();
        return {bus.select, bus.number7, bus.number6, bus.number5, bus.number4,
                bus.number3, bus.number2, bus.number1, bus.number0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_sel  = 1'b0;
        m_hold = 1'b0;
        m_win.delete();
    endtask

    // Drive one cycle of inputs, then apply the same cycle to the model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic s,
                        input logic f, input logic a);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.flush    = f;
        bus.out_ack  = a;
        @(posedge clk);
        if (f) begin
            m_win.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (a) m_hold = 1'b0;
        end else if (v) begin
            if (m_win.size() == 0) m_sel = s;
            m_mem[m_win.size()] = d;
            m_win.push_back(d);
            if (m_win.size() == 8) begin
                m_win.delete();
                m_hold = 1'b1;
                exp_q.push_back(model_window());
                pushed++;
            end
        end
        #1;
    endtask

    // Monitor: handshake flags and registers every cycle, full window on out_valid rise
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            check("in_ready", {64'd0, bus.in_ready}, {64'd0, !m_hold});
            check("out_valid", {64'd0, bus.out_valid}, {64'd0, m_hold});
            check("regs", dut_window(), model_window());
            if (bus.out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window: out_valid rose with no window expected at %0t", $time);
                end else begin
                    check("window", dut_window(), exp_q.pop_front());
                    popped++;
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sel   = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_regs", dut_window(), '0);
        check("reset_out_valid", {64'd0, bus.out_valid}, '0);
        check("reset_in_ready", {64'd0, bus.in_ready}, {64'd0, 1'b1});
        rst_n = 1'b1;

        // Back-to-back fill, select = max on the first sample
        for (int i = 0; i < 8; i++)
            step(1'b1, W'((i + 1) * 16), (i == 0) ? SEL_MAX : SEL_MIN, 1'b0, 1'b0);
        // Held window ignores further samples
        for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        // First sample after ack lands in number0 only; then abort it
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);

        // Gapped input; select comes from the first sample only
        for (int i = 0; i < 16; i++)
            step(i[0] == 1'b0, W'(8'hA0 + i), (i == 0) ? SEL_MIN : SEL_MAX, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);

        // Flush mid-fill, then a fresh window 1..8
        for (int i = 0; i < 5; i++) step(1'b1, W'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0);
        // Flush with ack in HOLD, then a partial new window
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, W'(8'h30 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));

        // Asynchronous reset in the middle of a window
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, W'(8'h90 + i), 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_regs", dut_window(), '0);
        check("async_rst_out_valid", {64'd0, bus.out_valid}, '0);
        model_reset();
        exp_q.delete();
        popped = pushed;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, W'(8'hE0 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        check("windows_seen", 65'(popped), 65'(pushed));
        check("scoreboard_empty", 65'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
